// File: rtl/wb_trace_checker.sv
// Write-back trace checker: compares each register-file write during RUN with a
// preloaded list of expected {register, value} entries and reports pass/fail.
module wb_trace_checker #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_waddr,
  input  logic [REG_AW-1:0]          exp_reg,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [$clog2(DEPTH):0]     exp_count,
  input  logic                       start,
  input  logic                       wb_en,
  input  logic [REG_AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       mismatch,
  output logic [15:0]                err_cnt,
  output logic [$clog2(DEPTH)-1:0]   first_idx,
  output logic [DATA_W-1:0]          first_got,
  output logic                       timeout,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int EW = REG_AW + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   entry;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wdog;
  logic            restart;
  logic            compare;
  logic            expire;
  logic            is_last;
  logic            differ;

  // NOTE: the expectation memory has no reset so it can map onto RAM, and its
  // contents deliberately survive a reset so a trace can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && exp_we) begin
      mem[exp_waddr] <= {exp_reg, exp_data};
    end
  end

  assign entry = mem[idx];

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    restart    = start && (state != S_RUN);
    compare    = (state == S_RUN) && wb_en;
    expire     = (state == S_RUN) && !wb_en && (wdog == WW'(TIMEOUT - 1));
    is_last    = ({1'b0, idx} == (count - CW'(1)));
    differ     = ({wb_addr, wb_data} != entry);
    unique case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if ((compare && is_last) || expire) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      idx       <= '0;
      wdog      <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      first_idx <= '0;
      first_got <= '0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (restart) begin
        count     <= (exp_count == '0) ? CW'(1) : exp_count;
        idx       <= '0;
        wdog      <= '0;
        err_cnt   <= '0;
        first_idx <= '0;
        first_got <= '0;
        timeout   <= 1'b0;
        overrun   <= 1'b0;
      end else if (compare) begin
        // A write-back on the expiry cycle is still compared and rearms the watchdog.
        wdog <= '0;
        idx  <= idx + AW'(1);
        if (differ) begin
          mismatch <= 1'b1;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          if (err_cnt == 16'd0) begin
            first_idx <= idx;
            first_got <= wb_data;
          end
        end
      end else if (expire) begin
        timeout <= 1'b1;
      end else if (state == S_RUN) begin
        wdog <= wdog + WW'(1);
      end else if (state == S_DONE && wb_en) begin
        overrun <= 1'b1;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 16'd0) && !timeout && !overrun;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Randomised scoreboard bench for wb_trace_checker with a gap-based reference model.
module tb_wb_trace_checker;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  logic              clk;
  logic              reset;
  logic              exp_we;
  logic [AW-1:0]     exp_waddr;
  logic [REG_AW-1:0] exp_reg;
  logic [DATA_W-1:0] exp_data;
  logic [CW-1:0]     exp_count;
  logic              start;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy, done, pass, mismatch, timeout, overrun;
  logic [15:0]       err_cnt;
  logic [AW-1:0]     first_idx;
  logic [DATA_W-1:0] first_got;

  wb_trace_checker #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_waddr(exp_waddr),
    .exp_reg(exp_reg), .exp_data(exp_data), .exp_count(exp_count),
    .start(start), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_cnt(err_cnt), .first_idx(first_idx), .first_got(first_got),
    .timeout(timeout), .overrun(overrun)
  );

  typedef struct {
    int                gap;
    logic [REG_AW-1:0] r;
    logic [DATA_W-1:0] d;
  } item_t;

  typedef struct {
    int                len;
    int                errs;
    int                fi;
    logic [DATA_W-1:0] fg;
    bit                to;
    bit                ov;
    bit                pass;
  } exp_t;

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [REG_AW-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  item_t             trace [$];
  exp_t              exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: walk the planned write-backs by elapsed gap; a gap longer than
  // TIMEOUT stalls the run, and anything arriving after the run ends is an overrun.
  function automatic exp_t model(input int cnt);
    exp_t e = '{default: 0};
    int   c   = (cnt == 0) ? 1 : cnt;
    int   idx = 0;
    int   t   = 0;
    bit   fin = 0;
    foreach (trace[i]) begin
      if (fin) begin
        e.ov = 1;
        continue;
      end
      if (trace[i].gap > TIMEOUT) begin
        e.to = 1; e.ov = 1; fin = 1; e.len = t + TIMEOUT;
        continue;
      end
      t += trace[i].gap;
      if (trace[i].r != mem_r[idx] || trace[i].d != mem_d[idx]) begin
        if (e.errs == 0) begin
          e.fi = idx;
          e.fg = trace[i].d;
        end
        e.errs++;
      end
      idx++;
      if (idx == c) begin
        fin = 1;
        e.len = t;
      end
    end
    if (!fin) begin
      e.to = 1;
      e.len = t + TIMEOUT;
    end
    e.pass = (e.errs == 0) && !e.to && !e.ov;
    return e;
  endfunction

  // Monitor: pops the expected result whenever the DUT reports completion.
  int   mm_seen  = 0;
  int   busy_cyc = 0;
  logic prev_done = 1'b0;
  logic prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      mm_seen = 0; busy_cyc = 0; prev_done = 1'b0; prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy)
        check("start_clears", {pass, done, timeout, overrun, err_cnt != 16'd0,
                               first_idx != '0, first_got != '0}, 64'd0);
      if (mismatch) mm_seen++;
      if (busy) busy_cyc++;
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("run_length", 64'(busy_cyc), 64'(mon_e.len));
          check("mismatch_pulses", 64'(mm_seen), 64'(mon_e.errs));
          check("err_cnt", 64'(err_cnt), 64'(mon_e.errs));
          check("first_idx", 64'(first_idx), 64'(mon_e.fi));
          check("first_got", 64'(first_got), 64'(mon_e.fg));
          check("timeout_at_done", 64'(timeout), 64'(mon_e.to));
        end
        mm_seen = 0;
        busy_cyc = 0;
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    exp_we = 1'b1; exp_waddr = AW'(a); exp_reg = r; exp_data = d;
    tick();
    exp_we = 1'b0;
    mem_r[a] = r;
    mem_d[a] = d;
  endtask

  task automatic add(input int gap, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    item_t it;
    it.gap = gap; it.r = r; it.d = d;
    trace.push_back(it);
  endtask

  task automatic match_trace(input int n, input int gap);
    trace.delete();
    for (int i = 0; i < n; i++) add(gap, mem_r[i], mem_d[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Driver: issues start and the planned trace; poke >= 0 asserts a stray start
  // in that item's first idle cycle (only used where the run is known to be active).
  task automatic run(input int cnt, input int poke);
    exp_t e;
    e = model(cnt);
    exp_q.push_back(e);
    exp_count = CW'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (trace[i]) begin
      for (int j = 1; j < trace[i].gap; j++) begin
        if (i == poke && j == 1) begin
          start = 1'b1;
          exp_count = CW'($urandom_range(1, DEPTH));
        end
        if ($urandom_range(0, 7) == 0) begin
          exp_we = 1'b1;
          exp_waddr = AW'($urandom);
          exp_reg = REG_AW'($urandom);
          exp_data = $urandom;
        end
        tick();
        start = 1'b0;
        exp_we = 1'b0;
      end
      wb_en = 1'b1; wb_addr = trace[i].r; wb_data = trace[i].d;
      tick();
      wb_en = 1'b0;
    end
    for (int k = 0; k < TIMEOUT + 4 && !done; k++) tick();
    check("done_reached", 64'(done), 64'd1);
    repeat (2) tick();
    check("overrun", 64'(overrun), 64'(e.ov));
    check("timeout", 64'(timeout), 64'(e.to));
    check("pass", 64'(pass), 64'(e.pass));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; exp_we = 1'b0; exp_waddr = '0; exp_reg = '0; exp_data = '0;
    exp_count = '0; start = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) tick();
    check("reset_flags", {busy, done, pass, mismatch, timeout, overrun}, 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    check("reset_first", {first_idx, first_got}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) load(i, REG_AW'($urandom), $urandom);
    load(0, 5'd0, 32'h0D);
    load(1, 5'd1, 32'h0C);
    load(2, 5'd2, 32'h10);

    // Matching trace, stray start mid-run must be ignored.
    match_trace(3, 4);
    run(3, 1);
    // Wrong data at idx 1.
    trace.delete();
    add(4, 5'd0, 32'h0D); add(4, 5'd1, 32'h0D); add(4, 5'd2, 32'h10);
    run(3, -1);
    // Wrong register, right data at idx 1.
    trace.delete();
    add(4, 5'd0, 32'h0D); add(4, 5'd3, 32'h0C); add(4, 5'd2, 32'h10);
    run(3, -1);
    // One write-back then silence: stall.
    trace.delete();
    add(4, 5'd0, 32'h0D);
    run(2, -1);
    // Extra write-back after completion, then a clean rerun.
    match_trace(3, 3);
    add(2, 5'd7, 32'h1234);
    run(3, -1);
    match_trace(3, 2);
    run(3, -1);
    // Gap exactly TIMEOUT survives; TIMEOUT+1 stalls.
    trace.delete();
    add(1, mem_r[0], mem_d[0]); add(TIMEOUT, mem_r[1], mem_d[1]); add(2, mem_r[2], mem_d[2]);
    run(3, -1);
    trace.delete();
    add(1, mem_r[0], mem_d[0]); add(TIMEOUT + 1, mem_r[1], mem_d[1]);
    run(3, -1);
    // Count of zero behaves as one.
    match_trace(1, 2);
    run(0, -1);

    // Reset mid-run clears everything asynchronously; memory is kept.
    pulse_reset();
    exp_count = CW'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    tick();
    wb_en = 1'b0;
    check("pre_reset_err_cnt", 64'(err_cnt), 64'd1);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_flags", {busy, done, pass, mismatch, timeout, overrun}, 64'd0);
    check("async_reset_err_cnt", 64'(err_cnt), 64'd0);
    check("async_reset_first", {first_idx, first_got}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_after_reset", {busy, done}, 64'd0);
    match_trace(3, 2);
    run(3, -1);

    // Full depth back-to-back, last entry wrong.
    match_trace(DEPTH, 1);
    trace[DEPTH-1].d = trace[DEPTH-1].d ^ 32'h1;
    run(DEPTH, -1);

    for (int it = 0; it < 40; it++) begin
      int cnt, n;
      if ($urandom_range(0, 3) == 0) begin
        pulse_reset();
        for (int k = 0; k < int'($urandom_range(1, 8)); k++)
          load(int'($urandom_range(0, 7)), REG_AW'($urandom), $urandom);
      end
      cnt = int'($urandom_range(1, 8));
      n = cnt;
      if ($urandom_range(0, 4) == 0) n = cnt + 1;
      if ($urandom_range(0, 5) == 0) n = int'($urandom_range(0, cnt - 1));
      trace.delete();
      for (int i = 0; i < n; i++) begin
        int sel, g;
        logic [REG_AW-1:0] r;
        logic [DATA_W-1:0] d;
        sel = int'($urandom_range(0, 9));
        g = (sel == 0) ? int'($urandom_range(TIMEOUT + 1, TIMEOUT + 3)) :
            (sel == 1) ? TIMEOUT : int'($urandom_range(1, 5));
        r = mem_r[i];
        d = mem_d[i];
        if ($urandom_range(0, 4) == 0) begin
          if ($urandom_range(0, 1) == 0) r = r ^ REG_AW'(1 << $urandom_range(0, REG_AW - 1));
          else d = d ^ (32'h1 << $urandom_range(0, DATA_W - 1));
        end
        add(g, r, d);
      end
      run(cnt, -1);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
